sid_i2s_tx: RTL
===============

# sid_i2s_tx

Serial audio output stage that takes the 16-bit filtered/volume-scaled sample stream from the SID filter and transmits it to an external I2S DAC. Each new sample is captured into a single holding register and converted to two's complement. The sample is then sent as a mono frame, duplicated on left and right, in standard I2S format. BCLK and LRCLK are derived from the system clock. Zero-order hold applies between frames, and there are sticky-free status pulses for underrun and dropped samples.

## Interface
- BCLK_DIV, 8: clk cycles per BCLK half-period; legal range ≥1.
- SIGNED_OUT, 1: 1 = invert sample MSB (unsigned→two's complement); 0 = pass through.

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous, active-low reset
- sample_in  in  16  unsigned sample from filter stage
- sample_valid  in  1  single-cycle strobe, sample_in valid (filter clk_en)
- enable  in  1  transmitter enable
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select, 0 = left
- i2s_sdata  out  1  serial data, MSB first
- underrun  out  1  1-cycle pulse: frame loaded with no fresh sample
- dropped  out  1  1-cycle pulse: fresh sample overwritten before use

## Operation
- Holding register `hold` (16 b) and `fresh` flag; a sample is always accepted, with no backpressure.
- sample_valid: hold ← sample_in; fresh ← 1. If fresh was already 1 and this is not a load cycle, pulse dropped.
- Conversion at load: W = SIGNED_OUT ? hold ^ 0x8000 : hold.
- Divider `div_cnt` runs 0..BCLK_DIV-1 while enable=1. At terminal count it wraps to 0 and bclk toggles.
  - fall strobe = terminal count with bclk=1.
  - rise strobe = terminal count with bclk=0.
- Slot counter `slot` (5 b, 0..31) advances mod 32 on each fall strobe.
- lrclk, sdata and the loads are all registered on the fall strobe, so they change on the same clk edge as bclk falls.
- Frame load happens on the fall strobe where slot goes 31→0:
  - W_prev ← W_cur.
  - W_cur ← conversion of hold, using the pre-edge hold value.
  - If fresh=1, clear fresh. Otherwise W_cur ← W_prev (repeat) and pulse underrun.
- sample_valid coinciding with a load cycle:
  - The load uses the old hold.
  - The new sample is stored with fresh=1.
  - No dropped pulse is generated.
  - The underrun decision is based on the old fresh.
- Per slot s (value after the fall edge):
  - lrclk = 0 for s 0..15 and 1 for s 16..31.
  - sdata for s=0 is W_prev[0].
  - sdata for s 1..15 is W_cur[16-s].
  - sdata for s=16 is W_cur[0].
  - sdata for s 17..31 is W_cur[32-s].
- enable=0 (synchronous):
  - div_cnt←0, bclk←0, slot←31, lrclk←1, sdata←0, W_prev←0.
  - hold, fresh and W_cur are retained.
  - underrun is suppressed; dropped still operates.
- Re-enable: the first fall strobe enters slot 0 and performs a frame load.

## Timing
- Reset values:
  - i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0, underrun=0, dropped=0.
  - slot=31, div_cnt=0, hold=0, fresh=0, W_cur=W_prev=0.
- Reset applied mid-frame forces all of the above immediately, with no partial-frame completion.
- BCLK period = 2·BCLK_DIV clk; frame = 64·BCLK_DIV clk; frame rate = f_clk/(64·BCLK_DIV).
- After enable rises, the first bclk rise occurs BCLK_DIV cycles later and the first fall occurs 2·BCLK_DIV cycles later, which is slot 0 / load.
- Latency:
  - sample_valid → load: at the next 31→0 fall strobe.
  - Load → left MSB on sdata: 2·BCLK_DIV clk.
- The DAC samples sdata on the bclk rise; data is stable for BCLK_DIV clk on each side of the rise.
- Status pulses are asserted exactly 1 clk, registered, in the cycle after the causing edge.

## Structure
- Package sid_audio_pkg holds:
  - SAMPLE_W=16.
  - SLOTS_PER_FRAME=32.
  - SLOT_MSB_L=1, SLOT_MSB_R=17.
  - A typedef for the slot index (logic[4:0]).
- Sub-module sid_i2s_clkgen contains div_cnt and bclk, and outputs bclk, fall_stb and rise_stb. It takes enable, clk and n_reset.
- The top level contains the holding register, frame/slot logic, output mux and status.

## Test plan
- Reset: hold n_reset low during activity, then release → bclk=0, lrclk=1, sdata=0, pulses 0. With BCLK_DIV=2 and enable=1, the first bclk rise is at clk 2 and the first fall at clk 4 with lrclk→0.
- SIGNED_OUT=1, BCLK_DIV=2, sample 0xFFFF before the load → W=0x7FFF.
  - Slot 1 sdata=0 and slots 2..15 =1.
  - Slot 16 =1 (LSB), slot 17 =0.
  - Next frame's slot 0 =1.
- Single sample 0x1234 (SIGNED_OUT=0), then none → frame 1 carries 0x1234 on L and R. Frame 2 repeats 0x1234 and underrun pulses once, at its load.
- Samples 0x0001 then 0x00F0 within one frame, no load between → dropped pulses once at the second sample, and the next frame transmits 0x00F0.
- sample_valid on the exact load cycle with fresh=0 → underrun pulses and the old value is repeated. The new sample is sent in the following frame with no dropped pulse.
- enable deasserted at slot 9 → next clk bclk=0, lrclk=1, sdata=0. After re-enable the frame restarts at slot 0 with the retained fresh sample.

Source files
------------

// File: rtl/sid_audio_pkg.sv
// Shared constants and helpers for the SID audio output path.
// Covers the sample width, the I2S slot layout and the DAC word conversion.
package sid_audio_pkg;

    localparam int SAMPLE_W        = 16;
    localparam int SLOTS_PER_FRAME = 32;
    localparam int SLOT_MSB_L      = 1;
    localparam int SLOT_MSB_R      = 17;

    typedef logic [4:0]          slot_t;
    typedef logic [SAMPLE_W-1:0] sample_t;

    localparam slot_t SLOT_LAST = slot_t'(SLOTS_PER_FRAME - 1);

    // Flipping the MSB turns offset-binary filter output into two's complement.
    function automatic sample_t to_dac_word(input sample_t s, input bit signed_out);
        return signed_out ? (s ^ {1'b1, {(SAMPLE_W-1){1'b0}}}) : s;
    endfunction

    // Word bit carried in slot s (1..31); slot 16 wraps to the left-channel LSB.
    function automatic logic [3:0] slot_bit(input slot_t s);
        if (s < slot_t'(SLOT_MSB_R - 1))
            return 4'(SLOT_MSB_L + SAMPLE_W - 1 - int'(s));
        else
            return 4'((SLOT_MSB_R + SAMPLE_W - 1 - int'(s)) % SAMPLE_W);
    endfunction

endpackage

// File: rtl/sid_i2s_clkgen.sv
// Bit-clock generator: divides clk by 2*BCLK_DIV and flags the clk cycle
// in which bclk is about to fall or rise.
module sid_i2s_clkgen #(
    parameter int BCLK_DIV = 8
) (
    input  logic clk,
    input  logic n_reset,
    input  logic enable_i,
    output logic bclk_o,
    output logic fall_stb_o,
    output logic rise_stb_o
);

    localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          bclk_q, bclk_d;
    logic          tc;

    always_comb begin
        tc        = enable_i && (div_cnt_q == CW'(BCLK_DIV - 1));
        div_cnt_d = div_cnt_q;
        bclk_d    = bclk_q;
        if (!enable_i) begin
            div_cnt_d = '0;
            bclk_d    = 1'b0;
        end else if (tc) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk_o     = bclk_q;
    assign fall_stb_o = tc & bclk_q;
    assign rise_stb_o = tc & ~bclk_q;

endmodule

// File: rtl/sid_i2s_tx.sv
// I2S transmitter for the SID output stage: single-sample holding register,
// mono frame duplicated on L/R, zero-order hold and underrun/drop pulses.
module sid_i2s_tx
    import sid_audio_pkg::*;
#(
    parameter int BCLK_DIV   = 8,
    parameter bit SIGNED_OUT = 1'b1
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                enable,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic                underrun,
    output logic                dropped
);

    logic fall_stb, rise_stb;

    sid_i2s_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
        .clk        (clk),
        .n_reset    (n_reset),
        .enable_i   (enable),
        .bclk_o     (i2s_bclk),
        .fall_stb_o (fall_stb),
        .rise_stb_o (rise_stb)
    );

    sample_t hold_q,  hold_d;
    logic    fresh_q, fresh_d;
    sample_t wcur_q,  wcur_d;
    sample_t wprev_q, wprev_d;
    slot_t   slot_q,  slot_d;
    logic    lrclk_q, lrclk_d;
    logic    sdata_q, sdata_d;
    logic    underrun_q, underrun_d;
    logic    dropped_q,  dropped_d;
    logic    load;

    always_comb begin
        load       = fall_stb && (slot_q == SLOT_LAST);
        hold_d     = sample_valid ? sample_in : hold_q;
        fresh_d    = fresh_q;
        wcur_d     = wcur_q;
        wprev_d    = wprev_q;
        slot_d     = slot_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        // Both status decisions use the pre-edge fresh flag.
        underrun_d = load && !fresh_q;
        dropped_d  = sample_valid && fresh_q && !load;

        if (load && fresh_q) fresh_d = 1'b0;
        if (sample_valid)    fresh_d = 1'b1;

        if (!enable) begin
            slot_d  = SLOT_LAST;
            lrclk_d = 1'b1;
            sdata_d = 1'b0;
            wprev_d = '0;
        end else if (fall_stb) begin
            slot_d  = slot_q + slot_t'(1);
            lrclk_d = slot_d[4];
            if (load) begin
                wprev_d = wcur_q;
                if (fresh_q) wcur_d = to_dac_word(hold_q, SIGNED_OUT);
            end
            // Slot 0 carries the previous frame's right LSB (one-bit I2S delay).
            sdata_d = (slot_d == '0) ? wprev_d[0] : wcur_q[slot_bit(slot_d)];
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            hold_q     <= '0;
            fresh_q    <= 1'b0;
            wcur_q     <= '0;
            wprev_q    <= '0;
            slot_q     <= SLOT_LAST;
            lrclk_q    <= 1'b1;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            fresh_q    <= fresh_d;
            wcur_q     <= wcur_d;
            wprev_q    <= wprev_d;
            slot_q     <= slot_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            dropped_q  <= dropped_d;
        end
    end

    assign i2s_lrclk = lrclk_q;
    assign i2s_sdata = sdata_q;
    assign underrun  = underrun_q;
    assign dropped   = dropped_q;

    // The DAC latches on the rise, so data and word select must hold across it.
    ap_stable_on_rise: assert property (@(posedge clk) disable iff (!n_reset)
        rise_stb |=> ($stable(i2s_sdata) && $stable(i2s_lrclk)));

endmodule
